// File: rtl/counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : counter_monitor
// Purpose  : Passive checker for a 4-mode up/down/load counter. Keeps a
//            one-deep history of the counter inputs and count, predicts the
//            next Q/RCO/LOAD, and flags and counts mismatches one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module counter_monitor #(
  parameter int WIDTH       = 4,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [1:0]       i_modo,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_rco,
  input  logic             i_load,
  output logic             o_sync,
  output logic             o_error,
  output logic [2:0]       o_fail_code,
  output logic [7:0]       o_err_count,
  output logic [7:0]       o_rco_count
);

  // Prediction arithmetic runs two bits wider than the count so the
  // carry-out of Q+3 is visible before truncation.
  localparam logic [WIDTH+1:0] c_m     = {2'b01, {WIDTH{1'b0}}};
  localparam logic [WIDTH+1:0] c_one   = (WIDTH+2)'(1);
  localparam logic [WIDTH+1:0] c_three = (WIDTH+2)'(3);

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_TRACK  = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sync;
  logic             r_error;
  logic [2:0]       r_fail_code;
  logic [7:0]       r_err_count;
  logic [7:0]       r_rco_count;

  logic [WIDTH-1:0] r_pq;
  logic             r_pen;
  logic [1:0]       r_pmodo;
  logic [WIDTH-1:0] r_pd;

  logic [WIDTH+1:0] w_pq_ext;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_pred_q;
  logic             w_pred_rco;
  logic             w_pred_load;
  logic [2:0]       w_mm;

  // One-deep history of what the counter saw on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pq    <= '0;
      r_pen   <= 1'b0;
      r_pmodo <= 2'b00;
      r_pd    <= '0;
    end else begin
      r_pq    <= i_q;
      r_pen   <= i_enable;
      r_pmodo <= i_modo;
      r_pd    <= i_d;
    end
  end

  // Ideal counter response to the recorded history.
  always_comb begin
    w_pq_ext    = {2'b00, r_pq};
    w_sum       = w_pq_ext;
    w_pred_rco  = 1'b0;
    w_pred_load = 1'b0;
    if (r_pen) begin
      case (r_pmodo)
        2'b00: begin
          w_sum      = w_pq_ext + c_three;
          w_pred_rco = (w_sum >= c_m);
        end
        2'b01: begin
          w_sum      = w_pq_ext + c_m - c_one;
          w_pred_rco = (r_pq == '0);
        end
        2'b10: begin
          w_sum      = w_pq_ext + c_one;
          w_pred_rco = &r_pq;
        end
        default: begin
          w_sum       = {2'b00, r_pd};
          w_pred_load = 1'b1;
        end
      endcase
    end
    w_pred_q = w_sum[WIDTH-1:0];
  end

  // Per-field mismatch vector, ordered to match the failure code: Q, RCO, LOAD.
  assign w_mm = {(w_pred_q != i_q), (w_pred_rco != i_rco), (w_pred_load != i_load)};

  // Checker FSM with registered status flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WARMUP;
      r_sync      <= 1'b0;
      r_error     <= 1'b0;
      r_fail_code <= 3'b000;
      r_err_count <= 8'd0;
      r_rco_count <= 8'd0;
    end else begin
      case (r_state)
        S_WARMUP: begin
          // History becomes valid on this edge; comparisons start next edge.
          r_state <= S_TRACK;
          r_sync  <= 1'b1;
        end
        S_TRACK: begin
          if (|w_mm) begin
            r_error <= 1'b1;
            if (!r_error) begin
              r_fail_code <= w_mm;
            end
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
            if (HALT_ON_ERR) begin
              r_state <= S_HALT;
              r_sync  <= 1'b0;
            end
          end
          if (i_rco && w_pred_rco) begin
            r_rco_count <= r_rco_count + 8'd1;
          end
        end
        S_HALT: begin
          // Frozen until reset; history keeps sampling independently.
          r_sync <= 1'b0;
        end
        default: begin
          r_state <= S_WARMUP;
          r_sync  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sync      = r_sync;
  assign o_error     = r_error;
  assign o_fail_code = r_fail_code;
  assign o_err_count = r_err_count;
  assign o_rco_count = r_rco_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_monitor
// Purpose  : Drives a behavioural counter (with fault injection) into two
//            counter_monitor instances and checks their status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   modo = 2'b00;
  logic [W-1:0] d = '0;
  logic [W-1:0] xq = '0;
  logic         xr = 1'b0;
  logic         xl = 1'b0;

  logic [W-1:0] cq = '0;
  logic         crco = 1'b0;
  logic         cload = 1'b0;

  logic         sync0, err0, sync1, err1;
  logic [2:0]   fc0, fc1;
  logic [7:0]   ec0, rc0, ec1, rc1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural counter: ideal next state, then optional injected faults.
  int   nqi;
  logic nr, nl;
  always_comb begin
    nqi = int'(cq);
    nr  = 1'b0;
    nl  = 1'b0;
    if (en) begin
      case (modo)
        2'd0: begin nqi = (int'(cq) + 3) % (1 << W); nr = (int'(cq) + 3) >= (1 << W); end
        2'd1: begin nqi = (int'(cq) + (1 << W) - 1) % (1 << W); nr = (cq == 0); end
        2'd2: begin nqi = (int'(cq) + 1) % (1 << W); nr = (int'(cq) == (1 << W) - 1); end
        default: begin nqi = int'(d); nl = 1'b1; end
      endcase
    end
  end

  always @(posedge clk) begin
    cq    <= W'(nqi) ^ xq;
    crco  <= nr ^ xr;
    cload <= nl ^ xl;
  end

  counter_monitor #(.WIDTH(W), .HALT_ON_ERR(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_modo(modo), .i_d(d),
    .i_q(cq), .i_rco(crco), .i_load(cload),
    .o_sync(sync0), .o_error(err0), .o_fail_code(fc0),
    .o_err_count(ec0), .o_rco_count(rc0)
  );

  counter_monitor #(.WIDTH(W), .HALT_ON_ERR(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_modo(modo), .i_d(d),
    .i_q(cq), .i_rco(crco), .i_load(cload),
    .o_sync(sync1), .o_error(err1), .o_fail_code(fc1),
    .o_err_count(ec1), .o_rco_count(rc1)
  );

  typedef struct {
    bit         rst;
    bit         sel;
    bit         en;
    bit [1:0]   m;
    bit [W-1:0] d;
    bit [W-1:0] xq;
    bit         xr;
    bit         xl;
    bit         sync;
    bit         err;
    bit [2:0]   fc;
    int         ec;
    int         rc;
  } vec_t;

  typedef struct {
    int idx;
    bit sel;
    bit sync;
    bit err;
    int fc;
    int ec;
    int rc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input int rst, input int sel, input int e, input int m, input int dd,
                     input int fq, input int fr, input int fl,
                     input int s, input int er, input int fc, input int ec, input int rc);
    vec_t v;
    v.rst = rst[0]; v.sel = sel[0]; v.en = e[0]; v.m = 2'(m); v.d = W'(dd);
    v.xq = W'(fq); v.xr = fr[0]; v.xl = fl[0];
    v.sync = s[0]; v.err = er[0]; v.fc = 3'(fc); v.ec = ec; v.rc = rc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): actual %0d, required %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input bit sel, input int idx, input int s, input int er,
                         input int fc, input int ec, input int rc);
    chk("sync",      idx, sel ? int'(sync1) : int'(sync0), s);
    chk("error",     idx, sel ? int'(err1)  : int'(err0),  er);
    chk("fail_code", idx, sel ? int'(fc1)   : int'(fc0),   fc);
    chk("err_count", idx, sel ? int'(ec1)   : int'(ec0),   ec);
    chk("rco_count", idx, sel ? int'(rc1)   : int'(rc0),   rc);
  endtask

  task automatic cmp(input exp_t e);
    chk_all(e.sel, e.idx, int'(e.sync), int'(e.err), e.fc, e.ec, e.rc);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clk);
      cmp(sb.pop_front());
      en = 1'b0; xq = '0; xr = 1'b0; xl = 1'b0;
    end
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic do_reset(input bit sel, input int idx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all(sel, idx, 0, 0, 0, 0, 0);
  endtask

  task automatic drv(input int e, input int m, input int dd, input int fq, input int fr, input int fl);
    @(negedge clk);
    rst_n = 1'b1;
    en = e[0]; modo = 2'(m); d = W'(dd); xq = W'(fq); xr = fr[0]; xl = fl[0];
  endtask

  initial begin
    exp_t e;
    // rst sel | en m d | xq xr xl | sync err fc ec rc
    // Clean run: load D, mode 00 wrap, mode 01 wrap, hold, mode 10 wrap, 00 boundaries.
    add(1,0, 1,3,13, 0,0,0, 1,0,0,0,0);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,1);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,1);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,1);
    add(0,0, 1,3,0,  0,0,0, 1,0,0,0,1);
    add(0,0, 1,1,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 1,1,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 0,1,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 0,2,5,  0,0,0, 1,0,0,0,2);
    add(0,0, 0,3,5,  0,0,0, 1,0,0,0,2);
    add(0,0, 0,0,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 0,2,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 1,2,0,  0,0,0, 1,0,0,0,2);
    add(0,0, 1,2,0,  0,0,0, 1,0,0,0,3);
    add(0,0, 1,3,12, 0,0,0, 1,0,0,0,3);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,3);
    add(0,0, 1,3,14, 0,0,0, 1,0,0,0,3);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,4);
    add(0,0, 1,3,15, 0,0,0, 1,0,0,0,4);
    add(0,0, 1,0,0,  0,0,0, 1,0,0,0,5);
    add(0,0, 0,0,0,  0,0,0, 1,0,0,0,5);
    add(0,0, 1,2,0,  0,0,0, 1,0,0,0,5);
    add(0,0, 0,2,0,  0,0,0, 1,0,0,0,5);
    add(0,0, 1,1,0,  0,0,0, 1,0,0,0,5);
    // Faults: Q+2 in mode 10, spurious RCO, triple mismatch, missing RCO.
    add(1,0, 1,3,2,  0,0,0, 1,0,0,0,0);
    add(0,0, 1,2,0,  7,0,0, 1,1,4,1,0);
    add(0,0, 1,2,0,  0,0,0, 1,1,4,1,0);
    add(0,0, 0,0,0,  0,1,0, 1,1,4,2,0);
    add(0,0, 1,3,7,  1,1,1, 1,1,4,3,0);
    add(0,0, 1,1,0,  0,0,0, 1,1,4,3,0);
    add(0,0, 1,3,0,  0,0,0, 1,1,4,3,0);
    add(0,0, 1,1,0,  0,1,0, 1,1,4,4,0);
    add(0,0, 1,1,0,  0,0,0, 1,1,4,4,0);
    // Five disabled cycles, then a spurious RCO while disabled.
    add(1,0, 1,3,9,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,0,0,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,1,3,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,2,0,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,3,4,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,0,0,  0,0,0, 1,0,0,0,0);
    add(0,0, 0,0,0,  0,1,0, 1,1,2,1,0);
    add(0,0, 1,2,0,  0,0,0, 1,1,2,1,0);
    // Halting instance: missing LOAD halts, later errors and RCOs ignored.
    add(1,1, 1,3,3,  0,0,0, 1,0,0,0,0);
    add(0,1, 1,3,4,  0,0,1, 0,1,1,1,0);
    add(0,1, 1,2,0,  1,0,0, 0,1,1,1,0);
    add(0,1, 1,1,0,  0,0,0, 0,1,1,1,0);
    add(0,1, 1,3,0,  0,0,0, 0,1,1,1,0);
    add(0,1, 1,1,0,  0,0,0, 0,1,1,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        drain();
        do_reset(tbl[i].sel, i);
      end
      @(negedge clk);
      if (sb.size() == 2) cmp(sb.pop_front());
      rst_n = 1'b1;
      en = tbl[i].en; modo = tbl[i].m; d = tbl[i].d;
      xq = tbl[i].xq; xr = tbl[i].xr; xl = tbl[i].xl;
      e.idx = i; e.sel = tbl[i].sel; e.sync = tbl[i].sync; e.err = tbl[i].err;
      e.fc = int'(tbl[i].fc); e.ec = tbl[i].ec; e.rc = tbl[i].rc;
      sb.push_back(e);
    end
    drain();

    // 300 consecutive Q mismatches saturate the error counter.
    do_reset(1'b0, 100);
    drv(1, 3, 0, 0, 0, 0);
    repeat (300) drv(1, 2, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("err_count", 101, int'(ec0), 255);
    chk("error",     101, int'(err0), 1);
    chk("fail_code", 101, int'(fc0), 4);

    // Asynchronous reset in the middle of a clock high phase.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(1'b0, 102, 0, 0, 0, 0, 0);

    // 257 correct RCO pulses: the RCO counter wraps to 1.
    repeat (257) begin
      drv(1, 3, 13, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_all(1'b0, 103, 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter WIDTH, default 4, sets the width of D and Q.
REQ-002 Parameter HALT_ON_ERR, default 0; when 1, the first mismatch freezes all checking.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 ENABLE  input  1  counter enable, as driven to the counter.
REQ-006 MODO  input  2  counter mode, as driven to the counter.
REQ-007 D  input  WIDTH  counter load value, as driven to the counter.
REQ-008 Q  input  WIDTH  counter count output.
REQ-009 RCO  input  1  counter ripple-carry output.
REQ-010 LOAD  input  1  counter load-indication output.
REQ-011 SYNC  output  1  high while the monitor is in TRACK with a valid prediction.
REQ-012 ERROR  output  1  sticky flag, set on the first mismatch.
REQ-013 FAIL_CODE  output  3  records the first mismatch type: bit2=Q, bit1=RCO, bit0=LOAD.
REQ-014 ERR_COUNT  output  8  number of mismatching cycles; saturates at 255.
REQ-015 RCO_COUNT  output  8  number of correct RCO pulses observed; wraps modulo 256.

Function
REQ-016 Counter contract, applied on a rising edge with ENABLE=1 and M=2^WIDTH:
- MODO=00: Q+3 mod M; RCO=1 iff Q+3>=M.
- MODO=01: Q-1 mod M; RCO=1 iff Q was 0.
- MODO=10: Q+1 mod M; RCO=1 iff Q was M-1.
- MODO=11: Q<=D; LOAD=1; RCO=0.
REQ-017 In every mode except 11, LOAD=0.
REQ-018 With ENABLE=0, the counter holds Q, and RCO=0 and LOAD=0.
REQ-019 At every rising edge, the monitor registers ENABLE, MODO, D and Q into a one-deep history stage (pQ, pEN, pMODO, pD).
REQ-020 At each edge, the prediction is f(pQ, pEN, pMODO, pD) per REQ-016 to REQ-018, computed in WIDTH+2 bits and then truncated.
REQ-021 At each edge, the prediction is compared with the current Q, RCO and LOAD; check latency is exactly one cycle after the counter edge.
REQ-022 FSM states are WARMUP, TRACK and HALT.
REQ-023 WARMUP is entered on reset; WARMUP->TRACK occurs on the first edge, once the history is valid.
REQ-024 No comparison is made in WARMUP.
REQ-025 TRACK->HALT occurs on a mismatch only when HALT_ON_ERR=1; HALT is left only by reset.
REQ-026 SYNC=1 only in TRACK.
REQ-027 On a mismatch in TRACK: ERROR is set, ERR_COUNT increments, and FAIL_CODE is loaded only if ERROR was previously 0.
REQ-028 Simultaneous Q, RCO and LOAD mismatches count as one error; FAIL_CODE captures all bits that mismatched in that cycle.
REQ-029 RCO_COUNT increments in TRACK when RCO=1 and the RCO prediction is 1.
REQ-030 A mismatched RCO does not increment RCO_COUNT.
REQ-031 ERR_COUNT holds at 255, with no wrap.
REQ-032 RCO_COUNT wraps from 255 to 0.
REQ-033 In HALT, all counters and flags hold their values; the history stage keeps sampling.
REQ-034 Wrap boundaries in REQ-016 are exact for every WIDTH; no off-by-one at M-1/0 or M-3..M-1 for mode 00.
REQ-035 ENABLE toggling cycle to cycle is legal; every cycle is checked independently.

Reset
REQ-036 RESET=0 asynchronously forces WARMUP, SYNC=0, ERROR=0, FAIL_CODE=000, ERR_COUNT=0, RCO_COUNT=0 and clears the history stage.
REQ-037 Reset mid-operation discards the pending prediction; checking resumes one edge after RESET rises.
REQ-038 Release of RESET is synchronised to the design only through the FSM; the first edge after release only fills the history.

Verification
REQ-039 WIDTH=4, load D=4'hD, then MODO=00 for 3 cycles (Q: D->0->3->6) -> RCO_COUNT=1, ERROR=0, SYNC=1.
REQ-040 MODO=01 from Q=0 with an ideal counter -> one RCO on the 0->F step; RCO_COUNT increments by 1; ERR_COUNT=0.
REQ-041 Faulty counter outputs Q+2 once in MODO=10 -> ERROR=1, FAIL_CODE=100, ERR_COUNT=1 one cycle after the bad Q.
REQ-042 LOAD held at 0 during MODO=11 with HALT_ON_ERR=1 -> FAIL_CODE=001, state HALT, SYNC=0, counts frozen despite later errors.
REQ-043 Force 300 mismatches -> ERR_COUNT saturates at 255; then RESET=0 mid-cycle -> all outputs zero immediately, asynchronously.
REQ-044 ENABLE=0 for 5 cycles with a stable Q -> no error; spurious RCO=1 injected -> FAIL_CODE=010, RCO_COUNT unchanged.
